pu_rf_mt: RTL and testbench
===========================

PU_RF_MT -- requirements
Module: pu_rf_mt

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each register.
REQ-002 SHALL have parameter DEPTH_NBITS, default 5, giving DEPTH = 2^DEPTH_NBITS registers per context.
REQ-003 SHALL have parameter CTX_NBITS, default 2, giving NCTX = 2^CTX_NBITS register contexts (threads).
REQ-004 SHALL have parameter BASE_INIT, default all-zero, a DEPTH*WIDTH vector; register i's init value = bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-005 SHALL have parameter ZERO_R0, default 1; when 1, register 0 of every context reads 0 and ignores writes.
REQ-006 SHALL have parameter BYPASS, default 1; when 1, same-cycle writes are forwarded to reads.
REQ-007 clk  in  1  sole clock, all state on rising edge.
REQ-008 rstn  in  1  reset, synchronous, active-low.
REQ-009 rd0_ctx, rd1_ctx  in  CTX_NBITS  read-port context selects.
REQ-010 rd0_addr, rd1_addr  in  DEPTH_NBITS  read-port register addresses.
REQ-011 dout0, dout1  out  WIDTH  registered read data.
REQ-012 wr0, wr1  in  1  write enables, ports 0 and 1.
REQ-013 wr0_ctx, wr1_ctx  in  CTX_NBITS; wr0_addr, wr1_addr  in  DEPTH_NBITS; din0, din1  in  WIDTH.
REQ-014 init_req  in  1  request to re-initialise one context to BASE_INIT.
REQ-015 init_ctx  in  CTX_NBITS  context to re-initialise, sampled with init_req.
REQ-016 init_busy  out  1; init_done  out  1 (one-cycle pulse); wr_blocked  out  2 (per-port dropped-write pulse).

Function
REQ-017 Reads SHALL have 1-cycle latency: dout[n] in cycle t+1 = contents of (rdn_ctx, rdn_addr) sampled at t.
REQ-018 With BYPASS=1, a read matching an accepted write's ctx/addr in the same cycle SHALL return that write's din; BYPASS=0 returns the pre-write value.
REQ-019 Writes SHALL take effect at the clock edge on which they are presented.
REQ-020 Both ports writing the same ctx/addr in one cycle: port 1 SHALL win; bypass SHALL forward port 1 data.
REQ-021 With ZERO_R0=1, address 0 writes SHALL be discarded (no wr_blocked) and address 0 reads SHALL return 0.
REQ-022 Init FSM states: IDLE, INIT. IDLE->INIT when init_req=1; init_ctx latched; address counter cleared to 0.
REQ-023 In INIT, each cycle SHALL write BASE_INIT entry [cnt] to (latched ctx, cnt) and increment cnt; after cnt = DEPTH-1 written, INIT->IDLE.
REQ-024 init_busy SHALL be 1 throughout INIT (exactly DEPTH cycles, starting the cycle after acceptance); init_done SHALL pulse 1 cycle on the first cycle back in IDLE.
REQ-025 init_req while init_busy=1 SHALL be ignored; init_req on the init_done cycle SHALL be accepted.
REQ-026 Port writes to the context under init while init_busy=1 SHALL be dropped and pulse the corresponding wr_blocked bit in the same cycle's following edge (registered, 1-cycle latency).
REQ-027 Port writes to other contexts during INIT SHALL proceed normally; reads of any context SHALL proceed, returning stored contents (init writes forwarded when BYPASS=1).
REQ-028 Address counter SHALL not wrap; DEPTH writes exactly per init.

Reset
REQ-029 While rstn=0 at a clock edge: all NCTX contexts SHALL load BASE_INIT (register 0 = 0 when ZERO_R0=1), dout0/dout1 = 0, FSM = IDLE, counter = 0, init_busy = 0, init_done = 0, wr_blocked = 0.
REQ-030 Reset asserted mid-INIT SHALL abort the sequence with no init_done pulse.
REQ-031 Write and init inputs SHALL be ignored in any cycle where rstn=0.

Verification
REQ-032 Reset with BASE_INIT[8]=0x0000_8000, release, read ctx 3 addr 8 -> dout0=0x0000_8000 next cycle; addr 0 -> 0.
REQ-033 wr0 ctx1 addr5 din 0xA5A5_0001 and wr1 ctx1 addr5 din 0x5A5A_0002 same cycle, rd0 same target -> dout0=0x5A5A_0002 (BYPASS=1); later read returns 0x5A5A_0002.
REQ-034 Write ctx2 addr7=0x1234, init_req ctx2 -> init_busy high 32 cycles, init_done pulse at cycle 33; read ctx2 addr7 -> BASE_INIT[7].
REQ-035 During ctx2 init: wr0 ctx2 addr4=0xDEAD -> wr_blocked[0] pulse, value not stored; wr1 ctx0 addr4=0xBEEF -> stored, readable as 0xBEEF.
REQ-036 init_req again at cycle 10 of INIT -> ignored, single init_done; rstn=0 at cycle 20 of a new INIT -> no init_done, all contexts = BASE_INIT.
REQ-037 wr0 addr0 din 0xFFFF_FFFF with ZERO_R0=1 -> read addr0 returns 0, wr_blocked stays 0.

Source files
------------

// File: rtl/pu_rf_mt.sv
// Multi-context register file with two read ports, two write ports and a
// per-context re-initialisation engine that replays BASE_INIT into one context.
module pu_rf_mt #(
    parameter int WIDTH       = 32,
    parameter int DEPTH_NBITS = 5,
    parameter int CTX_NBITS   = 2,
    parameter logic [(2**DEPTH_NBITS)*WIDTH-1:0] BASE_INIT = '0,
    parameter int ZERO_R0     = 1,
    parameter int BYPASS      = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [CTX_NBITS-1:0]   rd0_ctx,
    input  logic [DEPTH_NBITS-1:0] rd0_addr,
    input  logic [CTX_NBITS-1:0]   rd1_ctx,
    input  logic [DEPTH_NBITS-1:0] rd1_addr,
    output logic [WIDTH-1:0]       dout0,
    output logic [WIDTH-1:0]       dout1,
    input  logic                   wr0,
    input  logic [CTX_NBITS-1:0]   wr0_ctx,
    input  logic [DEPTH_NBITS-1:0] wr0_addr,
    input  logic [WIDTH-1:0]       din0,
    input  logic                   wr1,
    input  logic [CTX_NBITS-1:0]   wr1_ctx,
    input  logic [DEPTH_NBITS-1:0] wr1_addr,
    input  logic [WIDTH-1:0]       din1,
    input  logic                   init_req,
    input  logic [CTX_NBITS-1:0]   init_ctx,
    output logic                   init_busy,
    output logic                   init_done,
    output logic [1:0]             wr_blocked
);

    localparam int DEPTH     = 2**DEPTH_NBITS;
    localparam int NCTX      = 2**CTX_NBITS;
    localparam int IDX_NBITS = CTX_NBITS + DEPTH_NBITS;
    localparam int NENT      = NCTX * DEPTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [DEPTH_NBITS-1:0] cnt_q, cnt_d;
    logic [CTX_NBITS-1:0]   ctx_q, ctx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [1:0]             blk_q, blk_d;
    logic [WIDTH-1:0]       dout0_q, dout0_d;
    logic [WIDTH-1:0]       dout1_q, dout1_d;
    logic [WIDTH-1:0]       mem_q [NENT];
    logic [WIDTH-1:0]       mem_d [NENT];

    logic                   zero0_s, zero1_s;
    logic                   hit0_s, hit1_s;
    logic                   wr0_ok_s, wr1_ok_s;
    logic                   wr0_blk_s, wr1_blk_s;
    logic                   init_we_s;
    logic [IDX_NBITS-1:0]   init_idx_s, wr0_idx_s, wr1_idx_s;
    logic [WIDTH-1:0]       init_data_s;

    // Register 0 is hardwired to zero when ZERO_R0 is set, including its init value.
    function automatic logic [WIDTH-1:0] base_val(input int a);
        logic [WIDTH-1:0] v;
        v = BASE_INIT[a*WIDTH +: WIDTH];
        return ((ZERO_R0 != 0) && (a == 0)) ? {WIDTH{1'b0}} : v;
    endfunction

    // Forwarding priority: init write, then port 0, then port 1 (port 1 wins).
    function automatic logic [WIDTH-1:0] rd_fwd(input logic [CTX_NBITS-1:0] c,
                                                input logic [DEPTH_NBITS-1:0] a);
        logic [IDX_NBITS-1:0] idx;
        logic [WIDTH-1:0]     v;
        idx = {c, a};
        v   = mem_q[idx];
        v   = ((BYPASS != 0) && init_we_s && (init_idx_s == idx)) ? init_data_s : v;
        v   = ((BYPASS != 0) && wr0_ok_s && (wr0_idx_s == idx)) ? din0 : v;
        v   = ((BYPASS != 0) && wr1_ok_s && (wr1_idx_s == idx)) ? din1 : v;
        v   = ((ZERO_R0 != 0) && (a == {DEPTH_NBITS{1'b0}})) ? {WIDTH{1'b0}} : v;
        return v;
    endfunction

    assign zero0_s     = (ZERO_R0 != 0) && (wr0_addr == {DEPTH_NBITS{1'b0}});
    assign zero1_s     = (ZERO_R0 != 0) && (wr1_addr == {DEPTH_NBITS{1'b0}});
    assign hit0_s      = (state_q == ST_INIT) && (wr0_ctx == ctx_q);
    assign hit1_s      = (state_q == ST_INIT) && (wr1_ctx == ctx_q);
    assign wr0_ok_s    = wr0 && !zero0_s && !hit0_s;
    assign wr1_ok_s    = wr1 && !zero1_s && !hit1_s;
    assign wr0_blk_s   = wr0 && !zero0_s && hit0_s;
    assign wr1_blk_s   = wr1 && !zero1_s && hit1_s;
    assign init_we_s   = (state_q == ST_INIT) &&
                         !((ZERO_R0 != 0) && (cnt_q == {DEPTH_NBITS{1'b0}}));
    assign init_idx_s  = {ctx_q, cnt_q};
    assign wr0_idx_s   = {wr0_ctx, wr0_addr};
    assign wr1_idx_s   = {wr1_ctx, wr1_addr};
    assign init_data_s = base_val(int'(cnt_q));

    // Init sequencer next state: one BASE_INIT entry per cycle, no wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctx_d   = ctx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = {DEPTH_NBITS{1'b0}};
                    ctx_d   = init_ctx;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = {DEPTH_NBITS{1'b0}};
                end
            end
            ST_INIT: begin
                if (cnt_q == DEPTH_NBITS'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = {DEPTH_NBITS{1'b0}};
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_INIT;
                    cnt_d   = cnt_q + {{(DEPTH_NBITS-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {DEPTH_NBITS{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_INIT);
        blk_d  = {wr1_blk_s, wr0_blk_s};
    end

    // Storage next state; port 1 overrides port 0 on an address collision.
    always_comb begin
        for (int i = 0; i < NENT; i++) begin
            mem_d[i] = mem_q[i];
            mem_d[i] = (init_we_s && (init_idx_s == IDX_NBITS'(i))) ? init_data_s : mem_d[i];
            mem_d[i] = (wr0_ok_s && (wr0_idx_s == IDX_NBITS'(i))) ? din0 : mem_d[i];
            mem_d[i] = (wr1_ok_s && (wr1_idx_s == IDX_NBITS'(i))) ? din1 : mem_d[i];
        end
    end

    // Read data next state.
    always_comb begin
        dout0_d = rd_fwd(rd0_ctx, rd0_addr);
        dout1_d = rd_fwd(rd1_ctx, rd1_addr);
    end

    // State registers; reset reloads every context and aborts any init in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= {DEPTH_NBITS{1'b0}};
            ctx_q   <= {CTX_NBITS{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            blk_q   <= 2'b00;
            dout0_q <= {WIDTH{1'b0}};
            dout1_q <= {WIDTH{1'b0}};
            for (int i = 0; i < NENT; i++) begin
                mem_q[i] <= base_val(i % DEPTH);
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctx_q   <= ctx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            blk_q   <= blk_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
            for (int i = 0; i < NENT; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign dout0      = dout0_q;
    assign dout1      = dout1_q;
    assign init_busy  = busy_q;
    assign init_done  = done_q;
    assign wr_blocked = blk_q;

endmodule

// File: tb/tb_pu_rf_mt.sv
// Directed self-checking bench for pu_rf_mt: reset contents, dual-port writes,
// bypass, zero register and the context re-initialisation sequence.
module tb_pu_rf_mt;

    function automatic logic [31:0] base_entry(input int i);
        return (i == 8) ? 32'h0000_8000 : (32'hB0B0_0000 | 32'(i));
    endfunction

    function automatic logic [1023:0] mk_base();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = base_entry(i);
        return v;
    endfunction

    localparam logic [1023:0] BASE = mk_base();

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  rd0_ctx = 2'd0, rd1_ctx = 2'd0, wr0_ctx = 2'd0, wr1_ctx = 2'd0, init_ctx = 2'd0;
    logic [4:0]  rd0_addr = 5'd0, rd1_addr = 5'd0, wr0_addr = 5'd0, wr1_addr = 5'd0;
    logic [31:0] din0 = 32'd0, din1 = 32'd0;
    logic        wr0 = 1'b0, wr1 = 1'b0, init_req = 1'b0;
    logic [31:0] dout0, dout1;
    logic        init_busy, init_done;
    logic [1:0]  wr_blocked;

    int checks = 0;
    int errors = 0;

    pu_rf_mt #(
        .WIDTH(32), .DEPTH_NBITS(5), .CTX_NBITS(2),
        .BASE_INIT(BASE), .ZERO_R0(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rstn(rstn),
        .rd0_ctx(rd0_ctx), .rd0_addr(rd0_addr), .rd1_ctx(rd1_ctx), .rd1_addr(rd1_addr),
        .dout0(dout0), .dout1(dout1),
        .wr0(wr0), .wr0_ctx(wr0_ctx), .wr0_addr(wr0_addr), .din0(din0),
        .wr1(wr1), .wr1_ctx(wr1_ctx), .wr1_addr(wr1_addr), .din1(din1),
        .init_req(init_req), .init_ctx(init_ctx),
        .init_busy(init_busy), .init_done(init_done), .wr_blocked(wr_blocked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wr();
        wr0 = 1'b0;
        wr1 = 1'b0;
        init_req = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        wr0 = 1'b1; wr0_ctx = 2'd0; wr0_addr = 5'd3; din0 = 32'hDEAD_0003;
        init_req = 1'b1; init_ctx = 2'd1;
        tick();
        tick();
        checks++;
        if (dout0 !== 32'h0 || dout1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_dout: got %h/%h expected 0/0", dout0, dout1);
        end
        checks++;
        if ({init_busy, init_done, wr_blocked} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status: got %b expected 0000", {init_busy, init_done, wr_blocked});
        end
        clear_wr();
        rstn = 1'b1;
        rd0_ctx = 2'd0; rd0_addr = 5'd3;
        tick();
        checks++;
        if (init_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_init_ignored: got %b expected 0", init_busy);
        end
        checks++;
        if (dout0 !== 32'hB0B0_0003) begin
            errors++;
            $display("FAIL reset_wr_ignored: got %h expected b0b00003", dout0);
        end
    endtask

    task automatic test_reset_values();
        rd0_ctx = 2'd3; rd0_addr = 5'd8;
        rd1_ctx = 2'd3; rd1_addr = 5'd0;
        tick();
        checks++;
        if (dout0 !== 32'h0000_8000) begin
            errors++;
            $display("FAIL base_ctx3_a8: got %h expected 00008000", dout0);
        end
        checks++;
        if (dout1 !== 32'h0) begin
            errors++;
            $display("FAIL base_ctx3_a0: got %h expected 0", dout1);
        end
    endtask

    task automatic test_dual_write_bypass();
        wr0 = 1'b1; wr0_ctx = 2'd1; wr0_addr = 5'd5; din0 = 32'hA5A5_0001;
        wr1 = 1'b1; wr1_ctx = 2'd1; wr1_addr = 5'd5; din1 = 32'h5A5A_0002;
        rd0_ctx = 2'd1; rd0_addr = 5'd5;
        rd1_ctx = 2'd1; rd1_addr = 5'd6;
        tick();
        checks++;
        if (dout0 !== 32'h5A5A_0002) begin
            errors++;
            $display("FAIL dual_bypass: got %h expected 5a5a0002", dout0);
        end
        checks++;
        if (dout1 !== 32'hB0B0_0006) begin
            errors++;
            $display("FAIL dual_neighbour: got %h expected b0b00006", dout1);
        end
        clear_wr();
        wr0 = 1'b1; wr0_ctx = 2'd0; wr0_addr = 5'd9; din0 = 32'h0000_1111;
        rd1_ctx = 2'd0; rd1_addr = 5'd9;
        tick();
        clear_wr();
        checks++;
        if (dout0 !== 32'h5A5A_0002) begin
            errors++;
            $display("FAIL dual_stored: got %h expected 5a5a0002", dout0);
        end
        checks++;
        if (dout1 !== 32'h0000_1111) begin
            errors++;
            $display("FAIL port0_bypass: got %h expected 00001111", dout1);
        end
    endtask

    task automatic test_zero_r0();
        wr0 = 1'b1; wr0_ctx = 2'd1; wr0_addr = 5'd0; din0 = 32'hFFFF_FFFF;
        rd0_ctx = 2'd1; rd0_addr = 5'd0;
        tick();
        clear_wr();
        checks++;
        if (dout0 !== 32'h0 || wr_blocked !== 2'b00) begin
            errors++;
            $display("FAIL zero_r0_bypass: got %h/%b expected 0/00", dout0, wr_blocked);
        end
        tick();
        checks++;
        if (dout0 !== 32'h0 || wr_blocked !== 2'b00) begin
            errors++;
            $display("FAIL zero_r0_stored: got %h/%b expected 0/00", dout0, wr_blocked);
        end
    endtask

    task automatic test_init();
        int busy_cnt, done_cnt, done_at;
        wr0 = 1'b1; wr0_ctx = 2'd2; wr0_addr = 5'd7; din0 = 32'h0000_1234;
        tick();
        clear_wr();
        rd0_ctx = 2'd2; rd0_addr = 5'd7;
        tick();
        checks++;
        if (dout0 !== 32'h0000_1234) begin
            errors++;
            $display("FAIL init_prewrite: got %h expected 00001234", dout0);
        end
        init_req = 1'b1; init_ctx = 2'd2;
        tick();
        init_req = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            if (init_busy) busy_cnt++;
            if (init_done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            tick();
        end
        checks++;
        if (busy_cnt != 32) begin
            errors++;
            $display("FAIL init_busy_len: got %0d expected 32", busy_cnt);
        end
        checks++;
        if (done_at != 33 || done_cnt != 1) begin
            errors++;
            $display("FAIL init_done_pulse: got at %0d count %0d expected at 33 count 1", done_at, done_cnt);
        end
        rd0_ctx = 2'd2; rd0_addr = 5'd7;
        rd1_ctx = 2'd1; rd1_addr = 5'd5;
        tick();
        checks++;
        if (dout0 !== 32'hB0B0_0007) begin
            errors++;
            $display("FAIL init_restored: got %h expected b0b00007", dout0);
        end
        checks++;
        if (dout1 !== 32'h5A5A_0002) begin
            errors++;
            $display("FAIL init_other_ctx: got %h expected 5a5a0002", dout1);
        end
    endtask

    task automatic test_init_block();
        int waited;
        init_req = 1'b1; init_ctx = 2'd2;
        tick();
        init_req = 1'b0;
        tick();
        tick();
        wr0 = 1'b1; wr0_ctx = 2'd2; wr0_addr = 5'd4; din0 = 32'h0000_DEAD;
        wr1 = 1'b1; wr1_ctx = 2'd0; wr1_addr = 5'd4; din1 = 32'h0000_BEEF;
        rd0_ctx = 2'd1; rd0_addr = 5'd5;
        tick();
        clear_wr();
        checks++;
        if (wr_blocked !== 2'b01) begin
            errors++;
            $display("FAIL blocked_pulse: got %b expected 01", wr_blocked);
        end
        checks++;
        if (dout0 !== 32'h5A5A_0002) begin
            errors++;
            $display("FAIL read_during_init: got %h expected 5a5a0002", dout0);
        end
        tick();
        checks++;
        if (wr_blocked !== 2'b00) begin
            errors++;
            $display("FAIL blocked_clear: got %b expected 00", wr_blocked);
        end
        waited = 0;
        while (init_busy && waited < 40) begin
            tick();
            waited++;
        end
        checks++;
        if (init_busy !== 1'b0 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL block_init_end: got busy %b done %b expected 0 1", init_busy, init_done);
        end
        rd0_ctx = 2'd2; rd0_addr = 5'd4;
        rd1_ctx = 2'd0; rd1_addr = 5'd4;
        tick();
        checks++;
        if (dout0 !== 32'hB0B0_0004) begin
            errors++;
            $display("FAIL blocked_not_stored: got %h expected b0b00004", dout0);
        end
        checks++;
        if (dout1 !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL other_ctx_stored: got %h expected 0000beef", dout1);
        end
    endtask

    task automatic test_init_ignore_reset_abort();
        int busy_cnt, done_cnt, seen;
        wr0 = 1'b1; wr0_ctx = 2'd3; wr0_addr = 5'd6; din0 = 32'h0000_6666;
        tick();
        clear_wr();
        init_req = 1'b1; init_ctx = 2'd1;
        tick();
        init_req = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 1; k <= 45; k++) begin
            init_req = (k == 10);
            init_ctx = 2'd3;
            if (init_busy) busy_cnt++;
            if (init_done) done_cnt++;
            tick();
        end
        init_req = 1'b0;
        checks++;
        if (busy_cnt != 32 || done_cnt != 1) begin
            errors++;
            $display("FAIL req_while_busy: got busy %0d done %0d expected 32 1", busy_cnt, done_cnt);
        end
        rd0_ctx = 2'd3; rd0_addr = 5'd6;
        rd1_ctx = 2'd1; rd1_addr = 5'd5;
        tick();
        checks++;
        if (dout0 !== 32'h0000_6666 || dout1 !== 32'hB0B0_0005) begin
            errors++;
            $display("FAIL ignored_req_ctx: got %h/%h expected 00006666/b0b00005", dout0, dout1);
        end
        init_req = 1'b1; init_ctx = 2'd0;
        tick();
        init_req = 1'b0;
        for (int k = 1; k < 20; k++) tick();
        rstn = 1'b0;
        wr0 = 1'b1; wr0_ctx = 2'd2; wr0_addr = 5'd4; din0 = 32'h0000_DEAD;
        tick();
        clear_wr();
        checks++;
        if (init_busy !== 1'b0 || init_done !== 1'b0 || dout0 !== 32'h0) begin
            errors++;
            $display("FAIL abort_reset_state: got busy %b done %b dout0 %h expected 0 0 0", init_busy, init_done, dout0);
        end
        rstn = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (init_done || init_busy) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", seen);
        end
        rd0_ctx = 2'd0; rd0_addr = 5'd4;
        rd1_ctx = 2'd3; rd1_addr = 5'd6;
        tick();
        rd0_ctx = 2'd2; rd0_addr = 5'd4;
        checks++;
        if (dout0 !== 32'hB0B0_0004 || dout1 !== 32'hB0B0_0006) begin
            errors++;
            $display("FAIL reset_reload: got %h/%h expected b0b00004/b0b00006", dout0, dout1);
        end
        tick();
        checks++;
        if (dout0 !== 32'hB0B0_0004) begin
            errors++;
            $display("FAIL reset_wr_dropped: got %h expected b0b00004", dout0);
        end
    endtask

    task automatic test_back_to_back();
        int waited;
        wr0 = 1'b1; wr0_ctx = 2'd3; wr0_addr = 5'd10; din0 = 32'h0000_000A;
        wr1 = 1'b1; wr1_ctx = 2'd3; wr1_addr = 5'd11; din1 = 32'h0000_000B;
        tick();
        wr1 = 1'b0;
        wr0_addr = 5'd12; din0 = 32'h0000_000C;
        rd0_ctx = 2'd3; rd0_addr = 5'd10;
        rd1_ctx = 2'd3; rd1_addr = 5'd11;
        tick();
        clear_wr();
        checks++;
        if (dout0 !== 32'h0000_000A || dout1 !== 32'h0000_000B) begin
            errors++;
            $display("FAIL b2b_reads: got %h/%h expected 0000000a/0000000b", dout0, dout1);
        end
        rd0_addr = 5'd12;
        tick();
        checks++;
        if (dout0 !== 32'h0000_000C) begin
            errors++;
            $display("FAIL b2b_third: got %h expected 0000000c", dout0);
        end
        init_req = 1'b1; init_ctx = 2'd3;
        tick();
        init_req = 1'b0;
        waited = 0;
        while (!init_done && waited < 40) begin
            tick();
            waited++;
        end
        init_req = 1'b1; init_ctx = 2'd3;
        tick();
        init_req = 1'b0;
        checks++;
        if (init_busy !== 1'b1 || waited >= 40) begin
            errors++;
            $display("FAIL req_on_done: got busy %b after %0d cycles expected busy 1", init_busy, waited);
        end
        waited = 0;
        while (!init_done && waited < 40) begin
            tick();
            waited++;
        end
        rd0_ctx = 2'd3; rd0_addr = 5'd10;
        tick();
        checks++;
        if (waited >= 40 || dout0 !== 32'hB0B0_000A) begin
            errors++;
            $display("FAIL reinit_b2b: got %h after %0d cycles expected b0b0000a", dout0, waited);
        end
    endtask

    initial begin
        test_reset();
        test_reset_values();
        test_dual_write_bypass();
        test_zero_r0();
        test_init();
        test_init_block();
        test_init_ignore_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
